// File: rtl/ama_riscv_muldiv.sv
// RV32M multiply/divide unit for the EX stage: radix-2 shift-add multiply and restoring divide.
// Define MULDIV_FAST_MUL_EN to compute MUL* with one registered XLEN x XLEN product.
module ama_riscv_muldiv #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_a,
  input  logic [XLEN-1:0]  req_b,
  input  logic [TAG_W-1:0] req_tag,
  input  logic             flush,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_result,
  output logic [TAG_W-1:0] resp_tag,
  output logic             busy
);
  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned AW    = 2 * XLEN;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REMU   = 3'b111;
  localparam logic [XLEN-1:0] MIN_NEG = {1'b1, {(XLEN-1){1'b0}}};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_DONE = 2'd2} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [XLEN-1:0]  dvs_q, dvs_d;   // multiplicand or divisor magnitude
  logic [AW-1:0]    acc_q, acc_d;   // {product hi, multiplier/product lo} or {remainder, quotient}
  logic             neg_q, neg_d;
  logic             spec_q, spec_d;
  logic [XLEN-1:0]  result_q, result_d;
  logic [TAG_W-1:0] tag_q, tag_d;

  logic             a_signed, b_signed, a_neg, b_neg, b_zero, ovf, special;
  logic [XLEN-1:0]  mag_a, mag_b, spec_res;
  logic [AW-1:0]    mul_step, div_step, step_acc, prod_s;
  logic [XLEN:0]    div_shift, div_diff;
  logic [XLEN-1:0]  quo_s, rem_s, fin;
`ifndef MULDIV_FAST_MUL_EN
  logic [XLEN:0]    mul_sum;
`endif

  // Request decode: operand magnitudes, result sign and the no-iteration divide cases
  always_comb begin
    a_signed = (req_op != OP_MULHU) && (req_op != OP_DIVU) && (req_op != OP_REMU);
    b_signed = a_signed && (req_op != OP_MULHSU);
    a_neg    = a_signed & req_a[XLEN-1];
    b_neg    = b_signed & req_b[XLEN-1];
    mag_a    = a_neg ? (~req_a + XLEN'(1)) : req_a;
    mag_b    = b_neg ? (~req_b + XLEN'(1)) : req_b;
    b_zero   = (req_b == '0);
    ovf      = (req_a == MIN_NEG) && (req_b == '1);
    special  = req_op[2] && (b_zero || (ovf && !req_op[0]));
    if (b_zero) spec_res = req_op[1] ? req_a : '1;
    else        spec_res = req_op[1] ? '0 : MIN_NEG;
  end

  // One iteration of the datapath and the signed result it would produce
  always_comb begin
`ifdef MULDIV_FAST_MUL_EN
    mul_step = (cnt_q == CNT_W'(XLEN - 1)) ? acc_q : AW'(dvs_q) * AW'(acc_q[XLEN-1:0]);
`else
    mul_sum  = {1'b0, acc_q[AW-1:XLEN]} + (acc_q[0] ? {1'b0, dvs_q} : '0);
    mul_step = {mul_sum, acc_q[XLEN-1:1]};
`endif
    div_shift = {acc_q[AW-1:XLEN], acc_q[XLEN-1]};
    div_diff  = div_shift - {1'b0, dvs_q};
    div_step  = div_diff[XLEN] ? {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                               : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    if (spec_q)        step_acc = acc_q;
    else if (op_q[2])  step_acc = div_step;
    else               step_acc = mul_step;
    prod_s = neg_q ? (~step_acc + AW'(1)) : step_acc;
    quo_s  = neg_q ? (~step_acc[XLEN-1:0] + XLEN'(1)) : step_acc[XLEN-1:0];
    rem_s  = neg_q ? (~step_acc[AW-1:XLEN] + XLEN'(1)) : step_acc[AW-1:XLEN];
    if (spec_q) fin = step_acc[XLEN-1:0];
    else begin
      case (op_q)
        OP_MUL:                       fin = prod_s[XLEN-1:0];
        OP_MULH, OP_MULHSU, OP_MULHU: fin = prod_s[AW-1:XLEN];
        OP_DIV, OP_DIVU:              fin = quo_s;
        default:                      fin = rem_s;
      endcase
    end
  end

  // Next-state and register updates
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    dvs_d    = dvs_q;
    acc_d    = acc_q;
    neg_d    = neg_q;
    spec_d   = spec_q;
    result_d = result_q;
    tag_d    = tag_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid && !flush) begin
          state_d = S_BUSY;
          op_d    = req_op;
          tag_d   = req_tag;
          spec_d  = special;
          neg_d   = (req_op[2] && req_op[1]) ? a_neg : (a_neg ^ b_neg);
          dvs_d   = req_op[2] ? mag_b : mag_a;
          if (special) begin
            acc_d = {{XLEN{1'b0}}, spec_res};
            cnt_d = CNT_W'(XLEN - 1);
          end else begin
            acc_d = {{XLEN{1'b0}}, (req_op[2] ? mag_a : mag_b)};
`ifdef MULDIV_FAST_MUL_EN
            cnt_d = req_op[2] ? '0 : CNT_W'(XLEN - 2);
`else
            cnt_d = '0;
`endif
          end
        end
      end
      S_BUSY: begin
        if (flush) state_d = S_IDLE;
        else begin
          acc_d = step_acc;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == CNT_W'(XLEN - 1)) begin
            state_d  = S_DONE;
            result_d = fin;
          end
        end
      end
      S_DONE: begin
        if (flush || resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      dvs_q    <= '0;
      acc_q    <= '0;
      neg_q    <= 1'b0;
      spec_q   <= 1'b0;
      result_q <= '0;
      tag_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      dvs_q    <= dvs_d;
      acc_q    <= acc_d;
      neg_q    <= neg_d;
      spec_q   <= spec_d;
      result_q <= result_d;
      tag_q    <= tag_d;
    end
  end

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign resp_valid  = (state_q == S_DONE);
  assign resp_result = result_q;
  assign resp_tag    = tag_q;

endmodule

// File: tb/tb_ama_riscv_muldiv.sv
// Bench for ama_riscv_muldiv: random traffic against an arithmetic reference model,
// plus directed cases with literal results and latencies.
module tb_ama_riscv_muldiv;
`ifdef MULDIV_FAST_MUL_EN
  localparam int MUL_LAT = 2;
`else
  localparam int MUL_LAT = 32;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, flush, resp_valid, resp_ready, busy;
  logic [2:0]  req_op;
  logic [31:0] req_a, req_b, resp_result;
  logic [4:0]  req_tag, resp_tag;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_en   = 1'b0;

  // Reference model state: busy (not idle), valid (result held), edges left, expected result/tag
  logic        m_busy, m_valid;
  int          m_left;
  logic [31:0] m_res;
  logic [4:0]  m_tag;

  ama_riscv_muldiv #(.XLEN(32), .TAG_W(5)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_a(req_a), .req_b(req_b), .req_tag(req_tag), .flush(flush),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_tag(resp_tag), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs;
    logic [63:0] ua, ub, p;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'h0, a};
    ub  = {32'h0, b};
    ubs = $signed(ub);
    p   = 64'h0;
    case (op)
      3'd0: p = sa * sb;
      3'd1: p = sa * sb;
      3'd2: p = sa * ubs;
      3'd3: p = ua * ub;
      3'd4: if (b == 0) p = 64'hFFFF_FFFF;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h8000_0000;
            else p = sa / sb;
      3'd5: if (b == 0) p = 64'hFFFF_FFFF; else p = ua / ub;
      3'd6: if (b == 0) p = ua;
            else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) p = 64'h0;
            else p = sa % sb;
      default: if (b == 0) p = ua; else p = ua % ub;
    endcase
    return (op == 3'd1 || op == 3'd2 || op == 3'd3) ? p[63:32] : p[31:0];
  endfunction

  function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (op[2] && (b == 0 || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
    if (!op[2]) return MUL_LAT;
    return 32;
  endfunction

  // Transaction-level model: accept, count edges to the result, hold until taken or flushed
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 1'b0; m_valid <= 1'b0; m_left <= 0; m_res <= '0; m_tag <= '0;
    end else if (m_valid) begin
      if (flush || resp_ready) begin m_valid <= 1'b0; m_busy <= 1'b0; end
    end else if (m_busy) begin
      if (flush) m_busy <= 1'b0;
      else begin
        if (m_left == 1) m_valid <= 1'b1;
        m_left <= m_left - 1;
      end
    end else if (req_valid && !flush) begin
      m_busy <= 1'b1;
      m_left <= ref_lat(req_op, req_a, req_b);
      m_res  <= ref_res(req_op, req_a, req_b);
      m_tag  <= req_tag;
    end
  end

  always @(negedge clk) begin
    if (rst_n && cmp_en) begin
      chk("req_ready", 64'(req_ready), 64'(!m_busy));
      chk("busy", 64'(busy), 64'(m_busy));
      chk("resp_valid", 64'(resp_valid), 64'(m_valid));
      chk("resp_tag", 64'(resp_tag), 64'(m_tag));
      if (m_valid && resp_valid) chk("resp_result", 64'(resp_result), 64'(m_res));
    end
  end

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 7))
      0: return 32'h0;
      1: return 32'h8000_0000;
      2: return 32'hFFFF_FFFF;
      3: return 32'($urandom_range(0, 15));
      4: return -32'($urandom_range(1, 15));
      default: return $urandom;
    endcase
  endfunction

  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] tag, input logic [31:0] exp, input int exp_lat, input string nm);
    int n;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; req_tag = tag; flush = 1'b0; resp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk({nm, "_accept_wait"}, 64'(n), 64'(0));
    @(posedge clk); #1;
    req_valid = 1'b0; req_op = 3'($urandom); req_a = $urandom; req_b = $urandom; req_tag = 5'($urandom);
    n = 0;
    while (!resp_valid && n < 100) begin @(posedge clk); #1; n++; end
    chk({nm, "_latency"}, 64'(n), 64'(exp_lat));
    chk({nm, "_result"}, 64'(resp_result), 64'(exp));
    chk({nm, "_tag"}, 64'(resp_tag), 64'(tag));
  endtask

  task automatic take();
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1; resp_ready = 1'b0;
    chk("take_req_ready", 64'(req_ready), 64'(1));
    chk("take_resp_valid", 64'(resp_valid), 64'(0));
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    rst_n = 1'b0; req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0; req_tag = '0;
    flush = 1'b0; resp_ready = 1'b0;
    #1;
    chk("rst_req_ready", 64'(req_ready), 64'(1));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_resp_valid", 64'(resp_valid), 64'(0));
    chk("rst_result", 64'(resp_result), 64'(0));
    chk("rst_tag", 64'(resp_tag), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1; cmp_en = 1'b1;

    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, MUL_LAT, "mul");         take();
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, MUL_LAT, "mulhu"); take();
    do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0, MUL_LAT, "mulh");          take();
    do_op(3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, MUL_LAT, "mulhsu"); take();
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, 5'd5, 32'hFFFF_FFFD, 32, "div");               take();
    do_op(3'd6, 32'hFFFF_FFF9, 32'd2, 5'd6, 32'hFFFF_FFFF, 32, "rem");               take();
    do_op(3'd5, 32'hFFFF_FFF9, 32'd2, 5'd7, 32'h7FFF_FFFC, 32, "divu");              take();
    do_op(3'd7, 32'hFFFF_FFF9, 32'd2, 5'd8, 32'h1, 32, "remu");                      take();
    do_op(3'd5, 32'd5, 32'd0, 5'd9, 32'hFFFF_FFFF, 1, "divu_by0");                   take();
    do_op(3'd6, 32'd5, 32'd0, 5'd10, 32'd5, 1, "rem_by0");                           take();
    do_op(3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'h8000_0000, 1, "div_ovf");   take();
    do_op(3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'h0, 1, "rem_ovf");           take();

    // Held result stays stable, then a back-to-back request right after the handshake
    do_op(3'd0, 32'd1000, 32'd1234, 5'h15, 32'd1234000, MUL_LAT, "hold");
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold_result", 64'(resp_result), 64'(32'd1234000));
      chk("hold_tag", 64'(resp_tag), 64'(5'h15));
      chk("hold_req_ready", 64'(req_ready), 64'(0));
    end
    take();
    do_op(3'd5, 32'd100, 32'd7, 5'h16, 32'd14, 32, "b2b"); take();

    // Flush at cycle 10 of a divide
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd4; req_a = 32'd1000; req_b = 32'd3; req_tag = 5'd17;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (9) @(posedge clk);
    #1; flush = 1'b1;
    @(posedge clk); #1; flush = 1'b0;
    chk("flush_resp_valid", 64'(resp_valid), 64'(0));
    chk("flush_req_ready", 64'(req_ready), 64'(1));
    chk("flush_busy", 64'(busy), 64'(0));
    n = 0;
    for (int i = 0; i < 40; i++) begin @(posedge clk); #1; if (resp_valid) n++; end
    chk("flush_no_resp", 64'(n), 64'(0));

    // Asynchronous reset in the middle of a multiply
    @(negedge clk);
    req_valid = 1'b1; req_op = 3'd0; req_a = 32'd3; req_b = 32'd9; req_tag = 5'd18;
    @(posedge clk); #1; req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #3; rst_n = 1'b0;
    #1;
    chk("arst_req_ready", 64'(req_ready), 64'(1));
    chk("arst_busy", 64'(busy), 64'(0));
    chk("arst_resp_valid", 64'(resp_valid), 64'(0));
    chk("arst_result", 64'(resp_result), 64'(0));
    chk("arst_tag", 64'(resp_tag), 64'(0));
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // Random traffic checked every cycle by the compare process
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      req_valid  = ($urandom_range(0, 3) != 0);
      req_op     = 3'($urandom_range(0, 7));
      req_a      = pick();
      req_b      = pick();
      req_tag    = 5'($urandom);
      flush      = ($urandom_range(0, 199) == 0);
      resp_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    req_valid = 1'b0; flush = 1'b0; resp_ready = 1'b1;
    repeat (40) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
